// File: rtl/dmem_bus_unit_pkg.sv
// Shared encodings for the data-memory bus unit: access sizes, fault causes, FSM states.
package dmem_bus_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCESS    = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCESS   = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RESP  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // The reserved size never counts as aligned, so it always faults.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~addr_lo[0];
            SIZE_WORD: return (addr_lo == 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bus_unit_load_extend.sv
// Combinational load alignment: shifts the bus word down to the addressed lane
// and zero- or sign-extends byte/half results.
module load_extend
    import dmem_bus_unit_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_signed,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = data >> {addr_lo, 3'b000};
        case (size)
            SIZE_BYTE: result = {{24{load_signed & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = {{16{load_signed & shifted[15]}}, shifted[15:0]};
            default:   result = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_bus_unit.sv
// Data-memory bus unit bridging the memory stage to the external ACKD_n-handshaked bus.
// Optional bus timeout (access fault after TIMEOUT_CYCLES) enabled by defining DMEM_TIMEOUT_EN.
module dmem_bus_unit
    import dmem_bus_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_req,
    input  logic        m_write,
    input  logic [1:0]  m_size,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic        m_load_signed,
    input  logic        m_kill,
    output logic        m_stall,
    output logic        m_done,
    output logic        m_fault,
    output logic [3:0]  m_cause,
    output logic [31:0] m_rdata,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    output logic [31:0] DAD,
    output logic [31:0] DDT_out,
    output logic        DDT_oe,
    input  logic [31:0] DDT_in,
    input  logic        ACKD_n
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("dmem_bus_unit: TIMEOUT_CYCLES out of range 1..1023");
    end

    state_e      state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        signed_q, signed_d;
    logic        kill_q, kill_d;
    logic        mreq_q, mreq_d;
    logic        bus_write_q, bus_write_d;
    logic        ddt_oe_q, ddt_oe_d;
    logic [31:0] ddt_out_q, ddt_out_d;
    logic [31:0] dad_q, dad_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_result;
    logic        killed;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0]  cnt_q, cnt_d;
`endif

    load_extend u_load_extend (
        .data        (DDT_in),
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .load_signed (signed_q),
        .result      (load_result)
    );

    // A kill seen at any point of the bus cycle only suppresses the completion pulse.
    assign killed = kill_q | m_kill;

    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        write_d     = write_q;
        signed_d    = signed_q;
        kill_d      = kill_q;
        mreq_d      = mreq_q;
        bus_write_d = bus_write_q;
        ddt_oe_d    = ddt_oe_q;
        ddt_out_d   = ddt_out_q;
        dad_d       = dad_q;
        cause_d     = cause_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        rdata_d     = 32'h0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m_req && !m_kill) begin
                    if (!is_aligned(m_size, m_addr[1:0])) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        cause_d = m_write ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
                    end else begin
                        state_d     = ST_BUS;
                        addr_lo_d   = m_addr[1:0];
                        size_d      = m_size;
                        write_d     = m_write;
                        signed_d    = m_load_signed;
                        kill_d      = 1'b0;
                        mreq_d      = 1'b1;
                        bus_write_d = m_write;
                        ddt_oe_d    = m_write;
                        dad_d       = {m_addr[31:2], 2'b00};
                        ddt_out_d   = m_write ? (m_wdata << {m_addr[1:0], 3'b000}) : 32'h0;
`ifdef DMEM_TIMEOUT_EN
                        cnt_d       = 10'd0;
`endif
                    end
                end
            end
            ST_BUS: begin
                kill_d = killed;
                if (!ACKD_n) begin
                    state_d     = ST_RESP;
                    mreq_d      = 1'b0;
                    bus_write_d = 1'b0;
                    ddt_oe_d    = 1'b0;
                    done_d      = ~killed;
                    rdata_d     = (write_q || killed) ? 32'h0 : load_result;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_FAULT;
                    mreq_d      = 1'b0;
                    bus_write_d = 1'b0;
                    ddt_oe_d    = 1'b0;
                    fault_d     = ~killed;
                    cause_d     = write_q ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
`endif
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_lo_q   <= 2'b00;
            size_q      <= 2'b00;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            kill_q      <= 1'b0;
            mreq_q      <= 1'b0;
            bus_write_q <= 1'b0;
            ddt_oe_q    <= 1'b0;
            ddt_out_q   <= 32'h0;
            dad_q       <= 32'h0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            cause_q     <= 4'h0;
            rdata_q     <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q       <= 10'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            write_q     <= write_d;
            signed_q    <= signed_d;
            kill_q      <= kill_d;
            mreq_q      <= mreq_d;
            bus_write_q <= bus_write_d;
            ddt_oe_q    <= ddt_oe_d;
            ddt_out_q   <= ddt_out_d;
            dad_q       <= dad_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
            rdata_q     <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // A flush arriving during the fault cycle still cancels the pulse.
    assign m_fault = fault_q & ~m_kill;
    assign m_done  = done_q;
    assign m_cause = cause_q;
    assign m_rdata = rdata_q;
    assign m_stall = m_req & ~m_done & ~m_fault;
    assign MREQ    = mreq_q;
    assign WRITE   = bus_write_q;
    assign SIZE    = size_q;
    assign DAD     = dad_q;
    assign DDT_out = ddt_out_q;
    assign DDT_oe  = ddt_oe_q;

endmodule

// File: tb/tb_dmem_bus_unit.sv
// Directed self-checking bench for dmem_bus_unit; timeout cases run only when
// DMEM_TIMEOUT_EN is defined, otherwise an indefinite-wait case runs instead.
module tb_dmem_bus_unit;

    logic        clk;
    logic        rst;
    logic        m_req;
    logic        m_write;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_load_signed;
    logic        m_kill;
    logic        m_stall;
    logic        m_done;
    logic        m_fault;
    logic [3:0]  m_cause;
    logic [31:0] m_rdata;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic [31:0] DAD;
    logic [31:0] DDT_out;
    logic        DDT_oe;
    logic [31:0] DDT_in;
    logic        ACKD_n;

    int checks = 0;
    int errors = 0;

    dmem_bus_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .m_req         (m_req),
        .m_write       (m_write),
        .m_size        (m_size),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_load_signed (m_load_signed),
        .m_kill        (m_kill),
        .m_stall       (m_stall),
        .m_done        (m_done),
        .m_fault       (m_fault),
        .m_cause       (m_cause),
        .m_rdata       (m_rdata),
        .MREQ          (MREQ),
        .WRITE         (WRITE),
        .SIZE          (SIZE),
        .DAD           (DAD),
        .DDT_out       (DDT_out),
        .DDT_oe        (DDT_oe),
        .DDT_in        (DDT_in),
        .ACKD_n        (ACKD_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic wr, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic sgn, input logic kill, input logic ackn,
                                 input logic [31:0] din);
        m_req         = req;
        m_write       = wr;
        m_size        = sz;
        m_addr        = addr;
        m_wdata       = wdata;
        m_load_signed = sgn;
        m_kill        = kill;
        ACKD_n        = ackn;
        DDT_in        = din;
        #1;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    // Aligned access acknowledged in its first bus cycle.
    task automatic runSimple(input string tag, input logic wr, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic sgn,
                             input logic [31:0] din, input logic [31:0] exp_dad,
                             input logic [31:0] exp_out, input logic [31:0] exp_rdata);
        nextCycle;
        applyStimulus(1'b1, wr, sz, addr, wdata, sgn, 1'b0, 1'b1, 32'h0);
        checkOutput({tag, ".stall_req"}, 32'(m_stall), 32'd1);
        checkOutput({tag, ".mreq_req"}, 32'(MREQ), 32'd0);
        nextCycle;
        applyStimulus(1'b1, wr, sz, addr, wdata, sgn, 1'b0, 1'b0, din);
        checkOutput({tag, ".mreq_bus"}, 32'(MREQ), 32'd1);
        checkOutput({tag, ".dad"}, DAD, exp_dad);
        checkOutput({tag, ".write"}, 32'(WRITE), 32'(wr));
        checkOutput({tag, ".size"}, 32'(SIZE), 32'(sz));
        checkOutput({tag, ".oe"}, 32'(DDT_oe), 32'(wr));
        checkOutput({tag, ".stall_bus"}, 32'(m_stall), 32'd1);
        if (wr) checkOutput({tag, ".ddt_out"}, DDT_out, exp_out);
        nextCycle;
        applyStimulus(1'b1, wr, sz, addr, wdata, sgn, 1'b0, 1'b1, 32'h0);
        checkOutput({tag, ".done"}, 32'(m_done), 32'd1);
        checkOutput({tag, ".rdata"}, m_rdata, exp_rdata);
        checkOutput({tag, ".stall_resp"}, 32'(m_stall), 32'd0);
        checkOutput({tag, ".mreq_resp"}, 32'(MREQ), 32'd0);
        nextCycle;
        idle;
        checkOutput({tag, ".done_clr"}, 32'(m_done), 32'd0);
        checkOutput({tag, ".rdata_clr"}, m_rdata, 32'h0);
    endtask

    task automatic runMisaligned(input string tag, input logic wr, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [3:0] exp_cause);
        nextCycle;
        applyStimulus(1'b1, wr, sz, addr, 32'h5555AAAA, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput({tag, ".stall_req"}, 32'(m_stall), 32'd1);
        nextCycle;
        applyStimulus(1'b1, wr, sz, addr, 32'h5555AAAA, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput({tag, ".mreq"}, 32'(MREQ), 32'd0);
        checkOutput({tag, ".fault"}, 32'(m_fault), 32'd1);
        checkOutput({tag, ".cause"}, 32'(m_cause), 32'(exp_cause));
        checkOutput({tag, ".stall"}, 32'(m_stall), 32'd0);
        nextCycle;
        idle;
        checkOutput({tag, ".fault_clr"}, 32'(m_fault), 32'd0);
        checkOutput({tag, ".mreq_clr"}, 32'(MREQ), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle;
        nextCycle;
        nextCycle;
        checkOutput("reset.mreq", 32'(MREQ), 32'd0);
        checkOutput("reset.write", 32'(WRITE), 32'd0);
        checkOutput("reset.oe", 32'(DDT_oe), 32'd0);
        checkOutput("reset.done", 32'(m_done), 32'd0);
        checkOutput("reset.fault", 32'(m_fault), 32'd0);
        checkOutput("reset.rdata", m_rdata, 32'h0);
        checkOutput("reset.dad", DAD, 32'h0);
        checkOutput("reset.stall", 32'(m_stall), 32'd0);
        rst = 1'b0;

        $display("[TB] directed loads and stores");
        runSimple("lw",   1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 32'h100, 32'h0, 32'hDEADBEEF);
        runSimple("lb",   1'b0, 2'b00, 32'h103, 32'h0, 1'b1, 32'h80000000, 32'h100, 32'h0, 32'hFFFFFF80);
        runSimple("lbu",  1'b0, 2'b00, 32'h103, 32'h0, 1'b0, 32'h80000000, 32'h100, 32'h0, 32'h00000080);
        runSimple("lh",   1'b0, 2'b01, 32'h102, 32'h0, 1'b1, 32'h80017F00, 32'h100, 32'h0, 32'hFFFF8001);
        runSimple("lhu",  1'b0, 2'b01, 32'h102, 32'h0, 1'b0, 32'h80017F00, 32'h100, 32'h0, 32'h00008001);
        runSimple("lh0",  1'b0, 2'b01, 32'h000, 32'h0, 1'b1, 32'h1234ABCD, 32'h000, 32'h0, 32'hFFFFABCD);
        runSimple("lb1",  1'b0, 2'b00, 32'h101, 32'h0, 1'b1, 32'h00007F00, 32'h100, 32'h0, 32'h0000007F);
        runSimple("sb",   1'b1, 2'b00, 32'h201, 32'h12345678, 1'b0, 32'hFFFFFFFF, 32'h200, 32'h34567800, 32'h0);
        runSimple("sw",   1'b1, 2'b10, 32'h300, 32'hCAFEF00D, 1'b0, 32'hFFFFFFFF, 32'h300, 32'hCAFEF00D, 32'h0);

        $display("[TB] store with four wait states");
        nextCycle;
        applyStimulus(1'b1, 1'b1, 2'b01, 32'h202, 32'h0000ABCD, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("sh.stall_req", 32'(m_stall), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            nextCycle;
            applyStimulus(1'b1, 1'b1, 2'b01, 32'h202, 32'h0000ABCD, 1'b0, 1'b0,
                          (i == 5) ? 1'b0 : 1'b1, 32'h0);
            checkOutput("sh.oe", 32'(DDT_oe), 32'd1);
            checkOutput("sh.mreq", 32'(MREQ), 32'd1);
            checkOutput("sh.dad", DAD, 32'h200);
            checkOutput("sh.ddt_out", DDT_out, 32'hABCD0000);
            checkOutput("sh.done_wait", 32'(m_done), 32'd0);
        end
        nextCycle;
        applyStimulus(1'b1, 1'b1, 2'b01, 32'h202, 32'h0000ABCD, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("sh.done", 32'(m_done), 32'd1);
        checkOutput("sh.oe_off", 32'(DDT_oe), 32'd0);
        checkOutput("sh.write_off", 32'(WRITE), 32'd0);
        checkOutput("sh.rdata", m_rdata, 32'h0);
        nextCycle;
        idle;

        $display("[TB] misaligned accesses");
        runMisaligned("lw_mis", 1'b0, 2'b10, 32'h101, 4'd4);
        runMisaligned("sw_mis", 1'b1, 2'b10, 32'h102, 4'd6);
        runMisaligned("rsvd",   1'b0, 2'b11, 32'h100, 4'd4);
        runMisaligned("sh_mis", 1'b1, 2'b01, 32'h201, 4'd6);

        $display("[TB] kill handling");
        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        nextCycle;
        idle;
        checkOutput("kill_idle.mreq", 32'(MREQ), 32'd0);
        checkOutput("kill_idle.fault", 32'(m_fault), 32'd0);

        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h101, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h101, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
        checkOutput("kill_fault.fault", 32'(m_fault), 32'd0);
        nextCycle;
        idle;

        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
        checkOutput("kill_bus.mreq1", 32'(MREQ), 32'd1);
        nextCycle;
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h12345678);
        checkOutput("kill_bus.mreq2", 32'(MREQ), 32'd1);
        nextCycle;
        idle;
        checkOutput("kill_bus.done", 32'(m_done), 32'd0);
        checkOutput("kill_bus.mreq_off", 32'(MREQ), 32'd0);
        checkOutput("kill_bus.rdata", m_rdata, 32'h0);
        nextCycle;
        idle;

        $display("[TB] reset during a bus cycle");
        applyStimulus(1'b1, 1'b1, 2'b10, 32'h400, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h0);
        nextCycle;
        applyStimulus(1'b1, 1'b1, 2'b10, 32'h400, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("rst_bus.mreq_on", 32'(MREQ), 32'd1);
        rst = 1'b1;
        nextCycle;
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_bus.mreq", 32'(MREQ), 32'd0);
        checkOutput("rst_bus.oe", 32'(DDT_oe), 32'd0);
        checkOutput("rst_bus.dad", DAD, 32'h0);
        checkOutput("rst_bus.done", 32'(m_done), 32'd0);
        rst = 1'b0;
        nextCycle;
        idle;
        checkOutput("rst_bus.done_after", 32'(m_done), 32'd0);
        checkOutput("rst_bus.fault_after", 32'(m_fault), 32'd0);
        checkOutput("rst_bus.mreq_after", 32'(MREQ), 32'd0);

`ifdef DMEM_TIMEOUT_EN
        $display("[TB] bus timeout");
        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            nextCycle;
            applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
            checkOutput("to_ld.mreq", 32'(MREQ), 32'd1);
        end
        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("to_ld.mreq_off", 32'(MREQ), 32'd0);
        checkOutput("to_ld.fault", 32'(m_fault), 32'd1);
        checkOutput("to_ld.cause", 32'(m_cause), 32'd5);
        checkOutput("to_ld.done", 32'(m_done), 32'd0);
        nextCycle;
        idle;
        checkOutput("to_ld.fault_clr", 32'(m_fault), 32'd0);

        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            nextCycle;
            applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0,
                          (i == 8) ? 1'b0 : 1'b1, 32'h11223344);
            checkOutput("to_ack.mreq", 32'(MREQ), 32'd1);
        end
        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("to_ack.done", 32'(m_done), 32'd1);
        checkOutput("to_ack.fault", 32'(m_fault), 32'd0);
        checkOutput("to_ack.rdata", m_rdata, 32'h11223344);
        nextCycle;
        idle;

        nextCycle;
        applyStimulus(1'b1, 1'b1, 2'b10, 32'h500, 32'h1, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            nextCycle;
            applyStimulus(1'b1, 1'b1, 2'b10, 32'h500, 32'h1, 1'b0, 1'b0, 1'b1, 32'h0);
        end
        checkOutput("to_st.fault", 32'(m_fault), 32'd1);
        checkOutput("to_st.cause", 32'(m_cause), 32'd7);
        checkOutput("to_st.oe", 32'(DDT_oe), 32'd0);
        nextCycle;
        idle;
`else
        $display("[TB] long wait without timeout");
        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            nextCycle;
            applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0,
                          (i == 20) ? 1'b0 : 1'b1, 32'hA5A5A5A5);
            checkOutput("wait.mreq", 32'(MREQ), 32'd1);
            checkOutput("wait.fault", 32'(m_fault), 32'd0);
        end
        nextCycle;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("wait.done", 32'(m_done), 32'd1);
        checkOutput("wait.rdata", m_rdata, 32'hA5A5A5A5);
        nextCycle;
        idle;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus_unit.md
DMEM_BUS_UNIT -- requirements
Module: dmem_bus_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning bus cycles waited for ACKD_n before an access fault (range 1..1023).
REQ-002 SHALL have port clk, in, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, in, 1: reset, synchronous, active-high.
REQ-004 SHALL have port m_req, in, 1: the memory stage requests an access; held with m_write/m_size/m_addr/m_wdata/m_load_signed stable until m_done or m_fault.
REQ-005 SHALL have port m_write, in, 1: 1 = store, 0 = load.
REQ-006 SHALL have port m_size, in, 2: access size; 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-007 SHALL have port m_addr, in, 32: byte address.
REQ-008 SHALL have port m_wdata, in, 32: store data, right-aligned.
REQ-009 SHALL have port m_load_signed, in, 1: sign-extend load result.
REQ-010 SHALL have port m_kill, in, 1: abort the pending request (pipeline flush).
REQ-011 SHALL have port m_stall, out, 1: freeze the pipeline.
REQ-012 SHALL have port m_done, out, 1: one-cycle completion pulse.
REQ-013 SHALL have port m_fault, out, 1: one-cycle fault pulse.
REQ-014 SHALL have port m_cause, out, 4: fault cause; 4 = load misaligned, 5 = load access fault, 6 = store misaligned, 7 = store access fault.
REQ-015 SHALL have port m_rdata, out, 32: extended load data, valid while m_done = 1.
REQ-016 SHALL have ports MREQ (out, 1), WRITE (out, 1), SIZE (out, 2), DAD (out, 32), DDT_out (out, 32), DDT_oe (out, 1), DDT_in (in, 32) and ACKD_n (in, 1, active-low acknowledge): the external data bus.

Function
REQ-017 SHALL implement the FSM IDLE -> BUS -> RESP -> IDLE, plus IDLE -> FAULT -> IDLE.
REQ-018 In IDLE with m_req=1 and m_kill=0, SHALL check alignment: half requires addr[0]=0, word requires addr[1:0]=00, and size 11 always faults.
- Misaligned: go to FAULT; no bus cycle.
- Aligned: register the request and go to BUS.
REQ-019 In BUS, SHALL drive MREQ=1, WRITE=m_write, SIZE=m_size, DAD={addr[31:2],2'b00} from registers; for a store, SHALL also drive DDT_oe=1 and DDT_out=wdata shifted left by 8*addr[1:0].
REQ-020 In BUS, SHALL sample ACKD_n each cycle; on ACKD_n=0, SHALL capture DDT_in and go to RESP.
REQ-021 Load data SHALL be DDT_in shifted right by 8*addr[1:0], then zero- or sign-extended from bit 7 (byte) or bit 15 (half); word loads pass through unchanged.
REQ-022 RESP SHALL pulse m_done for one cycle, present m_rdata (0 for stores) and return to IDLE.
REQ-023 FAULT SHALL pulse m_fault for one cycle with m_cause per REQ-014 and return to IDLE.
REQ-024 m_stall SHALL equal m_req & ~m_done & ~m_fault, so minimum load/store latency is 3 cycles (request cycle, first BUS cycle with ack, RESP).
REQ-025 m_kill in IDLE or FAULT SHALL suppress acceptance and the fault pulse.
REQ-026 m_kill in BUS SHALL NOT abort the bus cycle; the cycle completes and the RESP pulse is suppressed.
REQ-027 MREQ, WRITE, DDT_oe SHALL be 0 in every state except BUS.
REQ-028 ACKD_n SHALL be ignored outside BUS.

Reset
REQ-029 While rst=1, SHALL set the state to IDLE, clear the timeout counter, and drive MREQ=WRITE=DDT_oe=m_done=m_fault=0 and m_rdata=DAD=0 from the next edge, including mid-BUS; the bus cycle is abandoned.

Configuration
REQ-030 With DMEM_TIMEOUT_EN defined, a counter SHALL clear on entry to BUS and increment each BUS cycle.
- Reaching TIMEOUT_CYCLES without ACKD_n=0: deassert MREQ and go to FAULT with cause 5 (load) or 7 (store).
- ACKD_n=0 in the same cycle as the limit: ACK wins.
REQ-031 Without DMEM_TIMEOUT_EN, SHALL have no counter; BUS waits indefinitely, and causes 5/7 are never produced.

Structure
REQ-032 A shared package SHALL hold the size encodings, the cause codes 4..7 and the FSM state enumeration.
REQ-033 Load alignment/extension SHALL be a combinational sub-module load_extend (inputs: data, addr[1:0], size, signed; output: 32-bit result).

Verification
REQ-034 Scenario: lw addr 0x100, DDT_in=0xDEADBEEF, ack on the 1st BUS cycle -> m_done in the 3rd cycle, m_rdata=0xDEADBEEF, m_stall high for 2 cycles.
REQ-035 Scenario: lb signed addr 0x103, DDT_in=0x80000000 -> m_rdata=0xFFFFFF80; lbu -> 0x00000080.
REQ-036 Scenario: sh addr 0x202, m_wdata=0x0000ABCD, ack after 4 wait cycles -> DAD=0x200, DDT_out=0xABCD0000, DDT_oe=1 for 5 cycles, m_done=1 then.
REQ-037 Scenario: lw addr 0x101 -> no MREQ, m_fault=1, m_cause=4; sw addr 0x102 -> m_cause=6.
REQ-038 Scenario: DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, ACKD_n held high on a load -> MREQ low after 8 BUS cycles, m_fault with m_cause=5; ack in the 8th cycle -> m_done instead.
REQ-039 Scenario: rst asserted mid-BUS -> MREQ=0 next cycle, state IDLE, no m_done/m_fault.
